seq_chunk_encoder: RTL

- Multi-cycle, parametrised successor to the combinational OR-tree encoder.
- Concatenates the two parties' input vectors into one S-bit word, {e_input, g_input}, with g_input in the low half.
- Scans the word one C-bit chunk per cycle. Produces either the OR-encoded index (one-hot inputs) or the highest-set-bit index (arbitrary inputs), plus a found flag.
- Latency is fixed and data-independent, as garbled-circuit sequential evaluation requires. Used in sequential garbling flows where a full-width combinational tree is too large per clock.

---
 rtl/seq_chunk_encoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_chunk_encoder.sv
// Sequential chunked index encoder.
// Scans the concatenated word {e_input, g_input} one C-bit chunk per cycle and reports either
// the OR of all set-bit indices (MODE 0) or the highest set-bit index (MODE 1), plus a found
// flag. Latency is fixed at N scan cycles plus one done cycle, independent of the data.
module seq_chunk_encoder #(
  parameter int unsigned logS = 4,
  parameter int unsigned logC = 2,
  parameter int unsigned MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2**(logS-1)-1:0]    g_input,
  input  logic [2**(logS-1)-1:0]    e_input,
  output logic                      busy,
  output logic                      done,
  output logic [logS-1:0]           o,
  output logic                      found
);

  localparam int unsigned S   = 2**logS;
  localparam int unsigned C   = 2**logC;
  localparam int unsigned KW  = logS - logC;
  // Counter keeps at least one bit so the logic stays uniform; with KW = 0 it is pinned at zero
  // and its contribution to the index is shifted out entirely.
  localparam int unsigned KWE = (KW > 0) ? KW : 1;
  localparam int unsigned N   = 2**KW;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [S-1:0]      data_q, data_d;
  logic [KWE-1:0]    k_q, k_d;
  logic [logS-1:0]   acc_o_q, acc_o_d;
  logic              acc_f_q, acc_f_d;
  logic [logS-1:0]   o_q, o_d;
  logic              found_q, found_d;

  logic [C-1:0]      chunk;
  logic              chunk_any;
  logic [logC-1:0]   local_idx;
  logic [logS-1:0]   idx;
  logic              last_chunk;

  // Select chunk k of the latched word.
  always_comb begin
    chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KWE'(i)) chunk = data_q[i*C +: C];
    end
  end

  assign chunk_any  = |chunk;
  assign last_chunk = (k_q == KWE'(N - 1));

  // Local chunk encoding: OR of set-bit positions, or highest set-bit position.
  always_comb begin
    local_idx = '0;
    for (int unsigned j = 0; j < C; j++) begin
      if (chunk[j]) begin
        if (MODE == 0) local_idx = local_idx | logC'(j);
        else           local_idx = logC'(j);
      end
    end
  end

  // Global index {k, local}; the shift drops the counter when there is only one chunk.
  assign idx = (logS'(k_q) << logC) | logS'(local_idx);

  // Next-state, accumulator and output-register updates.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    acc_o_d = acc_o_q;
    acc_f_d = acc_f_q;
    o_d     = o_q;
    found_d = found_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d  = {e_input, g_input};
          k_d     = '0;
          acc_o_d = '0;
          acc_f_d = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        acc_f_d = acc_f_q | chunk_any;
        if (chunk_any) begin
          if (MODE == 0) acc_o_d = acc_o_q | idx;
          else           acc_o_d = idx;
        end
        if (last_chunk) begin
          o_d     = acc_o_d;
          found_d = acc_f_d;
          state_d = StDone;
        end else begin
          k_d = k_q + KWE'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      k_q     <= '0;
      acc_o_q <= '0;
      acc_f_q <= 1'b0;
      o_q     <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      acc_o_q <= acc_o_d;
      acc_f_q <= acc_f_d;
      o_q     <= o_d;
      found_q <= found_d;
    end
  end

  assign busy  = (state_q == StScan);
  assign done  = (state_q == StDone);
  assign o     = o_q;
  assign found = found_q;

endmodule
